pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Instruction-fetch stage that sits directly upstream of the 14-bit program ROM (2K words, 11-bit address). It owns the program counter and the 8-level hardware call/return stack, drives the ROM address, and latches the returned word into the instruction register. It presents that instruction, its address, and a valid flag to the execute stage. Execute feeds back jump/call/return/skip requests; each redirect squashes exactly one fetched instruction, giving the 2-cycle branch cost of the PIC-style core.

## Interface
- ADDR_W, 11, program address width
- INSTR_W, 14, instruction width
- STACK_DEPTH, 8, call-stack entries
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-high
- stall  in  1  freeze all state this cycle
- Rom_addr_out  out  ADDR_W  ROM address (= PC register)
- Rom_data_in  in  INSTR_W  combinational ROM data for Rom_addr_out
- ir_out  out  INSTR_W  instruction register
- ir_pc_out  out  ADDR_W  address of the instruction in ir_out
- ir_valid  out  1  ir_out holds an executable instruction
- jump_req  in  1  GOTO or computed jump issued by the instruction in IR
- jump_target  in  ADDR_W  jump destination
- call_req  in  1  CALL issued by the instruction in IR
- call_target  in  ADDR_W  call destination
- ret_req  in  1  RETURN/RETLW issued by the instruction in IR
- skip_req  in  1  conditional skip taken by the instruction in IR
- stack_overflow  out  1  sticky; push attempted with stack full
- stack_underflow  out  1  sticky; pop attempted with stack empty

## Operation
- Reset values:
  - PC, Rom_addr_out, ir_pc_out = 0.
  - ir_out = 14'h0000 (NOP); ir_valid = 0.
  - Stack pointer, stack entry count, and both flags = 0.
  - Stack contents are don't-care.
- Requests are accepted only when stall=0 and ir_valid=1; otherwise they are ignored.
- Request priority: ret_req > call_req > jump_req > skip_req. Only the highest-priority request acts.
- Normal cycle (no accepted request, stall=0):
  - ir_out <= Rom_data_in; ir_pc_out <= PC; ir_valid <= 1.
  - PC <= PC+1, wrapping 11'h7FF -> 11'h000.
- jump: PC <= jump_target; ir_out <= NOP; ir_valid <= 0.
- call:
  - Push ir_pc_out+1 (mod 2^ADDR_W) onto the stack.
  - PC <= call_target; IR squashed as for jump.
- ret:
  - Pop the top of stack into PC; IR squashed as for jump.
- skip: PC <= PC+1 as normal, but the fetched word is squashed (ir_out <= NOP, ir_valid <= 0).
- stall=1: PC, IR, ir_pc_out, ir_valid, stack and flags all hold.
- Stack behaviour:
  - Circular buffer of STACK_DEPTH entries.
  - Push writes at sp, then sp <= sp+1 mod 8. Pop sets sp <= sp-1 mod 8 and reads the new sp.
  - count saturates at 0..8.
  - Push at count=8 overwrites the oldest entry and sets stack_overflow.
  - Pop at count=0 still returns the wrapped entry and sets stack_underflow.
  - Flags clear only on rst.
- Reset asserted mid-operation forces the reset values immediately (asynchronous), including mid-branch or during stall.

## Timing
- Rom_addr_out is registered (it is the PC). The ROM is combinational, so Rom_data_in is sampled at the same edge.
- Fetch-to-IR latency is 1 cycle. After rst deasserts, the first edge gives ir_out=instr(0), ir_pc_out=0, ir_valid=1.
- A redirect accepted at edge n:
  - Rom_addr_out = target after edge n.
  - ir_valid = 0 for cycle n+1.
  - The target instruction is in IR with ir_valid=1 after edge n+1.
- Any branch therefore costs 2 cycles total; skip costs 1 bubble.
- Back-to-back redirects are impossible, because the bubble cycle has ir_valid=0 and requests are ignored.

## Structure
- Shared package `mcu_pkg`:
  - ADDR_W=11, INSTR_W=14, STACK_DEPTH=8.
  - NOP = 14'h0000.
  - Opcode-class constants for GOTO, CALL, RETURN, RETLW, shared with the decoder.
- One sub-module, `call_stack`: an 8×11 circular LIFO with push/pop inputs, top output, and overflow/underflow flags.
- pc_fetch_unit instantiates call_stack and holds the PC, IR and redirect priority logic.

## Test plan
- **Reset and sequential fetch.** Release rst with a ROM model holding words 0x3009, 0x00A4, 0x3005 at addresses 0..2.
  - Required: IR sequence 0x3009/0, 0x00A4/1, 0x3005/2, with ir_valid=1 from the first edge.
- **Jump.** jump_req, target 0x00B, while ir_pc_out=0x00E.
  - Required: next cycle ir_valid=0 and Rom_addr_out=0x00B; the following cycle ir_pc_out=0x00B and ir_valid=1.
- **Call and return.** call_req at ir_pc_out=0x010 with target 0x100, then ret_req at ir_pc_out=0x105.
  - Required: Rom_addr_out=0x011 after the return; both flags remain 0.
- **Nested calls.** Nine nested calls from addresses 0x000..0x008.
  - Required: stack_overflow=1. Eight returns yield 0x009, 0x008, …, 0x002. A ninth return sets stack_underflow=1.
- **Stall.** Hold stall for 3 cycles with jump_req asserted throughout.
  - Required: all outputs frozen; the jump is ignored; fetch resumes at PC+1 after stall drops.
- **Wrap, skip, async reset.**
  - PC at 0x7FF: required next Rom_addr_out=0x000.
  - skip_req: required exactly one ir_valid=0 cycle with no address discontinuity.
  - rst pulsed between clock edges: required immediate reset values.

Source files
------------

// File: rtl/mcu_pkg.sv
// Shared core constants: bus widths, NOP encoding, opcode classes and fetch redirect selects.
package mcu_pkg;

    localparam int ADDR_W      = 11;
    localparam int INSTR_W     = 14;
    localparam int STACK_DEPTH = 8;

    localparam logic [INSTR_W-1:0] NOP = 14'h0000;

    // Opcode classes shared with the decoder (top bits of the 14-bit word)
    localparam logic [2:0]         OPC_CALL   = 3'b100;
    localparam logic [2:0]         OPC_GOTO   = 3'b101;
    localparam logic [INSTR_W-1:0] OPC_RETURN = 14'h0008;
    localparam logic [3:0]         OPC_RETLW  = 4'b1101;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_RET,
        SEL_CALL,
        SEL_JUMP,
        SEL_SKIP
    } fetch_sel_e;

    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
        return pc + 1'b1;
    endfunction

endpackage

// File: rtl/call_stack.sv
// Circular hardware return stack with sticky overflow/underflow flags.
module call_stack
    import mcu_pkg::*;
#(
    parameter int DEPTH = STACK_DEPTH,
    parameter int W     = ADDR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] push_data_i,
    output logic [W-1:0] top_o,
    output logic         overflow_o,
    output logic         underflow_o
);

    localparam int              PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL  = (PTR_W+1)'(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] sp_q, sp_d, sp_dec;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             of_q, of_d;
    logic             uf_q, uf_d;

    // Pointer wraps naturally; an empty pop still reads the wrapped slot
    assign sp_dec      = sp_q - 1'b1;
    assign top_o       = mem_q[sp_dec];
    assign overflow_o  = of_q;
    assign underflow_o = uf_q;

    always_comb begin
        sp_d  = sp_q;
        cnt_d = cnt_q;
        of_d  = of_q;
        uf_d  = uf_q;
        if (push_i) begin
            sp_d = sp_q + 1'b1;
            if (cnt_q == FULL) of_d = 1'b1;
            else               cnt_d = cnt_q + 1'b1;
        end else if (pop_i) begin
            sp_d = sp_dec;
            if (cnt_q == '0) uf_d = 1'b1;
            else             cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[sp_q] <= push_data_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q  <= '0;
            cnt_q <= '0;
            of_q  <= 1'b0;
            uf_q  <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
            of_q  <= of_d;
            uf_q  <= uf_d;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: program counter, instruction register and redirect handling in front of the ROM.
module pc_fetch_unit
    import mcu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    output logic [ADDR_W-1:0]  Rom_addr_out,
    input  logic [INSTR_W-1:0] Rom_data_in,
    output logic [INSTR_W-1:0] ir_out,
    output logic [ADDR_W-1:0]  ir_pc_out,
    output logic               ir_valid,
    input  logic               jump_req,
    input  logic [ADDR_W-1:0]  jump_target,
    input  logic               call_req,
    input  logic [ADDR_W-1:0]  call_target,
    input  logic               ret_req,
    input  logic               skip_req,
    output logic               stack_overflow,
    output logic               stack_underflow
);

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               ir_valid_q, ir_valid_d;
    logic [ADDR_W-1:0]  stack_top;
    logic               push, pop;
    fetch_sel_e         sel;

    // Requests come from the instruction in IR, so a bubble or stall ignores them
    always_comb begin
        sel = SEL_SEQ;
        if (!stall && ir_valid_q) begin
            if (ret_req)       sel = SEL_RET;
            else if (call_req) sel = SEL_CALL;
            else if (jump_req) sel = SEL_JUMP;
            else if (skip_req) sel = SEL_SKIP;
        end
    end

    assign push = (sel == SEL_CALL);
    assign pop  = (sel == SEL_RET);

    always_comb begin
        pc_d       = pc_q;
        ir_pc_d    = ir_pc_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        if (!stall) begin
            ir_d       = NOP;
            ir_valid_d = 1'b0;
            case (sel)
                SEL_RET:  pc_d = stack_top;
                SEL_CALL: pc_d = call_target;
                SEL_JUMP: pc_d = jump_target;
                SEL_SKIP: pc_d = pc_inc(pc_q);
                default: begin
                    pc_d       = pc_inc(pc_q);
                    ir_d       = Rom_data_in;
                    ir_pc_d    = pc_q;
                    ir_valid_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= '0;
            ir_pc_q    <= '0;
            ir_q       <= NOP;
            ir_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            ir_pc_q    <= ir_pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    call_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (ADDR_W)
    ) u_call_stack (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .pop_i       (pop),
        .push_data_i (pc_inc(ir_pc_q)),
        .top_o       (stack_top),
        .overflow_o  (stack_overflow),
        .underflow_o (stack_underflow)
    );

    assign Rom_addr_out = pc_q;
    assign ir_out       = ir_q;
    assign ir_pc_out    = ir_pc_q;
    assign ir_valid     = ir_valid_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scenario bench for pc_fetch_unit with a behavioural fetch/stack model and randomized traffic.
module tb_pc_fetch_unit;
    import mcu_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               stall;
    logic [ADDR_W-1:0]  Rom_addr_out;
    logic [INSTR_W-1:0] Rom_data_in;
    logic [INSTR_W-1:0] ir_out;
    logic [ADDR_W-1:0]  ir_pc_out;
    logic               ir_valid;
    logic               jump_req, call_req, ret_req, skip_req;
    logic [ADDR_W-1:0]  jump_target, call_target;
    logic               stack_overflow, stack_underflow;

    logic [INSTR_W-1:0] rom [2048];
    assign Rom_data_in = rom[Rom_addr_out];

    always #5 clk = ~clk;

    pc_fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .Rom_addr_out    (Rom_addr_out),
        .Rom_data_in     (Rom_data_in),
        .ir_out          (ir_out),
        .ir_pc_out       (ir_pc_out),
        .ir_valid        (ir_valid),
        .jump_req        (jump_req),
        .jump_target     (jump_target),
        .call_req        (call_req),
        .call_target     (call_target),
        .ret_req         (ret_req),
        .skip_req        (skip_req),
        .stack_overflow  (stack_overflow),
        .stack_underflow (stack_underflow)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: architectural state as plain integers
    int m_pc, m_ir, m_irpc, m_valid, m_sp, m_cnt, m_of, m_uf;
    int m_stk [8];

    task automatic model_reset();
        m_pc = 0; m_ir = 0; m_irpc = 0; m_valid = 0;
        m_sp = 0; m_cnt = 0; m_of = 0; m_uf = 0;
    endtask

    task automatic model_step();
        if (rst) begin
            model_reset();
            return;
        end
        if (stall) return;
        if (m_valid != 0 && ret_req) begin
            m_sp = (m_sp + 7) % 8;
            if (m_cnt == 0) m_uf = 1; else m_cnt--;
            m_pc = m_stk[m_sp]; m_ir = 0; m_valid = 0;
        end else if (m_valid != 0 && call_req) begin
            m_stk[m_sp] = (m_irpc + 1) % 2048;
            m_sp = (m_sp + 1) % 8;
            if (m_cnt == 8) m_of = 1; else m_cnt++;
            m_pc = int'(call_target); m_ir = 0; m_valid = 0;
        end else if (m_valid != 0 && jump_req) begin
            m_pc = int'(jump_target); m_ir = 0; m_valid = 0;
        end else if (m_valid != 0 && skip_req) begin
            m_pc = (m_pc + 1) % 2048; m_ir = 0; m_valid = 0;
        end else begin
            m_ir = int'(rom[m_pc]); m_irpc = m_pc; m_valid = 1;
            m_pc = (m_pc + 1) % 2048;
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; jump_req = 0; call_req = 0; ret_req = 0; skip_req = 0;
        jump_target = '0; call_target = '0;
    endtask

    task automatic wait_valid_at(input int addr, output bit ok);
        ok = 0;
        for (int i = 0; i < 64; i++) begin
            if (ir_valid === 1'b1 && (addr < 0 || ir_pc_out === 11'(addr))) begin
                ok = 1;
                break;
            end
            cycle();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        model_reset();
        #12;
        n_checks++; if (Rom_addr_out !== 11'h000) begin n_fail++; $display("FAIL reset_addr got %h want 000", Rom_addr_out); end
        n_checks++; if (ir_out !== 14'h0000) begin n_fail++; $display("FAIL reset_ir got %h want 0000", ir_out); end
        n_checks++; if (ir_pc_out !== 11'h000) begin n_fail++; $display("FAIL reset_irpc got %h want 000", ir_pc_out); end
        n_checks++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", ir_valid); end
        n_checks++; if (stack_overflow !== 1'b0 || stack_underflow !== 1'b0) begin n_fail++; $display("FAIL reset_flags got %b%b want 00", stack_overflow, stack_underflow); end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        logic [13:0] exp_ir [3];
        exp_ir[0] = 14'h3009; exp_ir[1] = 14'h00A4; exp_ir[2] = 14'h3005;
        for (int k = 0; k < 3; k++) begin
            cycle();
            n_checks++; if (ir_out !== exp_ir[k] || ir_pc_out !== 11'(k) || ir_valid !== 1'b1) begin
                n_fail++; $display("FAIL seq_fetch%0d got ir=%h pc=%h v=%b want ir=%h pc=%h v=1", k, ir_out, ir_pc_out, ir_valid, exp_ir[k], k);
            end
        end
        n_checks++; if (Rom_addr_out !== 11'h003) begin n_fail++; $display("FAIL seq_addr got %h want 003", Rom_addr_out); end
    endtask

    task automatic test_jump();
        bit ok;
        wait_valid_at(11'h00E, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL jump_reach got pc=%h want 00E", ir_pc_out); end
        jump_req = 1; jump_target = 11'h00B;
        cycle();
        jump_req = 0;
        n_checks++; if (ir_valid !== 1'b0 || Rom_addr_out !== 11'h00B) begin n_fail++; $display("FAIL jump_bubble got v=%b addr=%h want v=0 addr=00B", ir_valid, Rom_addr_out); end
        cycle();
        n_checks++; if (ir_valid !== 1'b1 || ir_pc_out !== 11'h00B || ir_out !== rom[11]) begin n_fail++; $display("FAIL jump_target got v=%b pc=%h ir=%h want v=1 pc=00B ir=%h", ir_valid, ir_pc_out, ir_out, rom[11]); end
    endtask

    task automatic test_call_ret();
        bit ok;
        wait_valid_at(11'h010, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL call_reach got pc=%h want 010", ir_pc_out); end
        call_req = 1; call_target = 11'h100;
        cycle();
        call_req = 0;
        n_checks++; if (Rom_addr_out !== 11'h100 || ir_valid !== 1'b0) begin n_fail++; $display("FAIL call_addr got %h v=%b want 100 v=0", Rom_addr_out, ir_valid); end
        wait_valid_at(11'h105, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL ret_reach got pc=%h want 105", ir_pc_out); end
        ret_req = 1;
        cycle();
        ret_req = 0;
        n_checks++; if (Rom_addr_out !== 11'h011) begin n_fail++; $display("FAIL ret_addr got %h want 011", Rom_addr_out); end
        n_checks++; if (stack_overflow !== 1'b0 || stack_underflow !== 1'b0) begin n_fail++; $display("FAIL callret_flags got %b%b want 00", stack_overflow, stack_underflow); end
    endtask

    task automatic test_nested();
        bit ok;
        rst = 1;
        cycle();
        rst = 0;
        for (int k = 0; k < 9; k++) begin
            wait_valid_at(k, ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL nest_reach%0d got pc=%h want %h", k, ir_pc_out, k); end
            call_req = 1; call_target = 11'(k + 1);
            cycle();
            call_req = 0;
        end
        n_checks++; if (stack_overflow !== 1'b1 || stack_underflow !== 1'b0) begin n_fail++; $display("FAIL nest_overflow got of=%b uf=%b want of=1 uf=0", stack_overflow, stack_underflow); end
        for (int r = 0; r < 9; r++) begin
            wait_valid_at(-1, ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL nest_retwait%0d timed out", r); end
            ret_req = 1;
            cycle();
            ret_req = 0;
            n_checks++; if (Rom_addr_out !== 11'(m_pc)) begin n_fail++; $display("FAIL nest_ret%0d got %h want %h", r, Rom_addr_out, m_pc); end
            if (r < 8) begin
                n_checks++; if (Rom_addr_out !== 11'(9 - r) || stack_underflow !== 1'b0) begin n_fail++; $display("FAIL nest_retval%0d got %h uf=%b want %h uf=0", r, Rom_addr_out, stack_underflow, 9 - r); end
            end
        end
        n_checks++; if (stack_underflow !== 1'b1 || Rom_addr_out !== 11'h009) begin n_fail++; $display("FAIL nest_underflow got uf=%b addr=%h want uf=1 addr=009", stack_underflow, Rom_addr_out); end
    endtask

    task automatic test_stall();
        bit ok;
        logic [ADDR_W-1:0]  s_addr, s_irpc;
        logic [INSTR_W-1:0] s_ir;
        wait_valid_at(-1, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL stall_wait timed out"); end
        s_addr = Rom_addr_out; s_irpc = ir_pc_out; s_ir = ir_out;
        stall = 1; jump_req = 1; jump_target = 11'h3AA;
        for (int k = 0; k < 3; k++) begin
            cycle();
            n_checks++; if (Rom_addr_out !== s_addr || ir_out !== s_ir || ir_pc_out !== s_irpc || ir_valid !== 1'b1) begin
                n_fail++; $display("FAIL stall_hold%0d got addr=%h ir=%h pc=%h v=%b want addr=%h ir=%h pc=%h v=1", k, Rom_addr_out, ir_out, ir_pc_out, ir_valid, s_addr, s_ir, s_irpc);
            end
        end
        stall = 0; jump_req = 0;
        cycle();
        n_checks++; if (Rom_addr_out !== s_addr + 11'd1 || ir_pc_out !== s_addr || ir_valid !== 1'b1) begin
            n_fail++; $display("FAIL stall_resume got addr=%h pc=%h v=%b want addr=%h pc=%h v=1", Rom_addr_out, ir_pc_out, ir_valid, s_addr + 11'd1, s_addr);
        end
    endtask

    task automatic test_wrap_skip();
        bit ok;
        wait_valid_at(-1, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL wrap_wait timed out"); end
        jump_req = 1; jump_target = 11'h7FD;
        cycle();
        jump_req = 0;
        cycle();
        cycle();
        n_checks++; if (Rom_addr_out !== 11'h7FF) begin n_fail++; $display("FAIL wrap_top got %h want 7FF", Rom_addr_out); end
        cycle();
        n_checks++; if (Rom_addr_out !== 11'h000 || ir_pc_out !== 11'h7FF || ir_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_zero got addr=%h pc=%h v=%b want 000 7FF 1", Rom_addr_out, ir_pc_out, ir_valid); end
        skip_req = 1;
        cycle();
        skip_req = 0;
        n_checks++; if (ir_valid !== 1'b0 || ir_out !== 14'h0000 || Rom_addr_out !== 11'h001) begin n_fail++; $display("FAIL skip_bubble got v=%b ir=%h addr=%h want 0 0000 001", ir_valid, ir_out, Rom_addr_out); end
        cycle();
        n_checks++; if (ir_valid !== 1'b1 || ir_pc_out !== 11'h001 || Rom_addr_out !== 11'h002) begin n_fail++; $display("FAIL skip_resume got v=%b pc=%h addr=%h want 1 001 002", ir_valid, ir_pc_out, Rom_addr_out); end
        cycle();
        n_checks++; if (ir_valid !== 1'b1 || ir_pc_out !== 11'h002) begin n_fail++; $display("FAIL skip_single got v=%b pc=%h want 1 002", ir_valid, ir_pc_out); end
    endtask

    task automatic test_async_reset();
        bit ok;
        wait_valid_at(-1, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL areset_wait timed out"); end
        jump_req = 1; jump_target = 11'h155;
        cycle();
        jump_req = 0;
        #3; rst = 1; #1;
        n_checks++; if (Rom_addr_out !== 11'h000 || ir_out !== 14'h0000 || ir_pc_out !== 11'h000 || ir_valid !== 1'b0) begin
            n_fail++; $display("FAIL areset_branch got addr=%h ir=%h pc=%h v=%b want 000 0000 000 0", Rom_addr_out, ir_out, ir_pc_out, ir_valid);
        end
        n_checks++; if (stack_overflow !== 1'b0 || stack_underflow !== 1'b0) begin n_fail++; $display("FAIL areset_flags got %b%b want 00", stack_overflow, stack_underflow); end
        model_reset();
        @(posedge clk); #1;
        rst = 0;
        cycle(); cycle(); cycle();
        stall = 1;
        #3; rst = 1; #1;
        n_checks++; if (Rom_addr_out !== 11'h000 || ir_valid !== 1'b0 || ir_out !== 14'h0000) begin n_fail++; $display("FAIL areset_stall got addr=%h v=%b ir=%h want 000 0 0000", Rom_addr_out, ir_valid, ir_out); end
        model_reset();
        @(posedge clk); #1;
        rst = 0; stall = 0;
    endtask

    task automatic test_random();
        int r;
        for (int c = 0; c < 400; c++) begin
            r = int'($urandom_range(0, 15));
            stall       = ($urandom_range(0, 7) == 0);
            ret_req     = (r == 0) || (r == 5);
            call_req    = (r == 1) || (r == 5) || (r == 6);
            jump_req    = (r == 2) || (r == 6) || (r == 7);
            skip_req    = (r == 3) || (r == 7) || (r == 5);
            jump_target = 11'($urandom);
            call_target = 11'($urandom);
            cycle();
            n_checks++; if (Rom_addr_out !== 11'(m_pc) || ir_valid !== (m_valid != 0) || ir_out !== 14'(m_ir)) begin
                n_fail++; $display("FAIL rand_state c=%0d got addr=%h v=%b ir=%h want addr=%h v=%0d ir=%h", c, Rom_addr_out, ir_valid, ir_out, m_pc, m_valid, m_ir);
            end
            if (m_valid != 0) begin
                n_checks++; if (ir_pc_out !== 11'(m_irpc)) begin n_fail++; $display("FAIL rand_irpc c=%0d got %h want %h", c, ir_pc_out, m_irpc); end
            end
            n_checks++; if (stack_overflow !== (m_of != 0) || stack_underflow !== (m_uf != 0)) begin
                n_fail++; $display("FAIL rand_flags c=%0d got %b%b want %0d%0d", c, stack_overflow, stack_underflow, m_of, m_uf);
            end
        end
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) rom[i] = 14'($urandom);
        rom[0] = 14'h3009; rom[1] = 14'h00A4; rom[2] = 14'h3005;
        test_reset();
        test_sequential();
        test_jump();
        test_call_ret();
        test_nested();
        test_stall();
        test_wrap_skip();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
